// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; issues data-cache requests, stalls until dhit,
// registers the MEM/WB fields, keeps halt sticky and counts stall cycles.
module mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int SRC_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_alu_result,
    input  logic [WORD_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_wsel,
    input  logic [SRC_W-1:0]  ex_wdat_source,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_halt,
    input  logic [WORD_W-1:0] ex_instr_npc,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] alu_result,
    output logic [REG_W-1:0]  wsel,
    output logic [SRC_W-1:0]  wdat_source,
    output logic [WORD_W-1:0] instr_npc,
    output logic              halt,
    output logic [WORD_W-1:0] wb_dmemload,
    output logic [CNT_W-1:0]  stall_cycles
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
    state_t state, state_n;
    logic acc, mem_op, req, commit;
    always_comb begin
        acc    = ex_valid & ~flush & (state == IDLE);
        mem_op = acc & ~ex_halt & (ex_dREN | ex_dWEN);
        req    = ~RST & (mem_op | (state == WAIT));
        commit = (acc & (~mem_op | dhit)) | ((state == WAIT) & dhit);
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = (mem_op & ~dhit) ? WAIT : (commit & ex_halt) ? HALTED : IDLE;
        else if (state == WAIT && dhit)
            state_n = IDLE;
    end
    // A load that also asks to write is treated as a load only.
    always_comb begin
        dmemREN   = req & ex_dREN;
        dmemWEN   = req & ex_dWEN & ~ex_dREN;
        dmemaddr  = req ? ex_alu_result : '0;
        dmemstore = req ? ex_store_data : '0;
        mem_stall = req & ~dhit;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            wb_valid    <= 1'b0;
            alu_result  <= '0;
            wsel        <= '0;
            wdat_source <= '0;
            instr_npc   <= '0;
            halt        <= 1'b0;
            wb_dmemload <= '0;
        end else if (state == HALTED) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid    <= commit;
            alu_result  <= commit ? ex_alu_result : '0;
            wsel        <= commit ? ex_wsel : '0;
            wdat_source <= commit ? ex_wdat_source : '0;
            instr_npc   <= commit ? ex_instr_npc : '0;
            halt        <= commit & ex_halt;
            wb_dmemload <= (commit & dmemREN) ? dmemload : '0;
        end
    always_ff @(posedge CLK or posedge RST)
        if (RST) stall_cycles <= '0;
        else if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard queue of expected MEM/WB results.
module tb_mem_stage;
    logic CLK, RST, ex_valid, ex_dREN, ex_dWEN, ex_halt, flush, dhit;
    logic [31:0] ex_alu_result, ex_store_data, ex_instr_npc, dmemload;
    logic [4:0] ex_wsel;
    logic [1:0] ex_wdat_source;
    logic dmemREN, dmemWEN, mem_stall, wb_valid, halt;
    logic [31:0] dmemaddr, dmemstore, alu_result, instr_npc, wb_dmemload;
    logic [4:0] wsel;
    logic [1:0] wdat_source;
    logic [15:0] stall_cycles;
    logic n_ren, n_wen, n_stall, n_valid, n_halt;
    logic [31:0] n_addr, n_store, n_alu, n_npc, n_load;
    logic [4:0] n_wsel;
    logic [1:0] n_src;
    logic [3:0] n_cnt;
    int tests = 0, failed = 0;

    typedef struct {
        logic [31:0] alu, npc, dload;
        logic [4:0]  ws;
        logic [1:0]  src;
        logic        h;
    } exp_t;
    exp_t q[$];

    mem_stage dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_wsel(ex_wsel), .ex_wdat_source(ex_wdat_source),
        .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_halt(ex_halt), .ex_instr_npc(ex_instr_npc),
        .flush(flush), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_valid(wb_valid),
        .alu_result(alu_result), .wsel(wsel), .wdat_source(wdat_source), .instr_npc(instr_npc),
        .halt(halt), .wb_dmemload(wb_dmemload), .stall_cycles(stall_cycles)
    );

    mem_stage #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_wsel(ex_wsel), .ex_wdat_source(ex_wdat_source),
        .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_halt(ex_halt), .ex_instr_npc(ex_instr_npc),
        .flush(flush), .dhit(dhit), .dmemload(dmemload), .dmemREN(n_ren), .dmemWEN(n_wen),
        .dmemaddr(n_addr), .dmemstore(n_store), .mem_stall(n_stall), .wb_valid(n_valid),
        .alu_result(n_alu), .wsel(n_wsel), .wdat_source(n_src), .instr_npc(n_npc),
        .halt(n_halt), .wb_dmemload(n_load), .stall_cycles(n_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, rd, wr, h, input logic [31:0] alu, sd, input logic [4:0] ws,
                         input logic [1:0] src, input logic [31:0] npc);
        ex_valid = v; ex_dREN = rd; ex_dWEN = wr; ex_halt = h; ex_alu_result = alu;
        ex_store_data = sd; ex_wsel = ws; ex_wdat_source = src; ex_instr_npc = npc;
    endtask

    task automatic push(input logic [31:0] alu, npc, dload, input logic [4:0] ws,
                        input logic [1:0] src, input logic h);
        exp_t e;
        e.alu = alu; e.npc = npc; e.dload = dload; e.ws = ws; e.src = src; e.h = h;
        q.push_back(e);
    endtask

    always @(negedge CLK)
        if (!RST && wb_valid) begin
            if (q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_unexpected: wb_valid=1 with alu_result=%h, required no result", alu_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_alu_result", alu_result, e.alu);
                chk("sb_wsel", {27'd0, wsel}, {27'd0, e.ws});
                chk("sb_wdat_source", {30'd0, wdat_source}, {30'd0, e.src});
                chk("sb_instr_npc", instr_npc, e.npc);
                chk("sb_halt", {31'd0, halt}, {31'd0, e.h});
                chk("sb_wb_dmemload", wb_dmemload, e.dload);
            end
        end

    initial begin
        RST = 1; flush = 0; dhit = 0; dmemload = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_halt", halt, 0);
        RST = 0;
        step();
        // load, 3-cycle miss
        drive(1, 1, 0, 0, 32'h100, 0, 5'd3, 2'd1, 32'h104);
        push(32'h100, 32'h104, 32'hDEADBEEF, 5'd3, 2'd1, 0);
        #1;
        chk("ld_dmemaddr", dmemaddr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", mem_stall, 1);
            chk("ld_dmemREN", dmemREN, 1);
            chk("ld_wait_wb_valid", wb_valid, 0);
            step();
        end
        dhit = 1; dmemload = 32'hDEADBEEF;
        #1;
        chk("ld_hit_stall", mem_stall, 0);
        step();
        dhit = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_stall_cycles", stall_cycles, 3);
        chk("ld_after_dmemREN", dmemREN, 0);
        step();
        // store, same-cycle hit
        drive(1, 0, 1, 0, 32'h200, 32'h12345678, 5'd0, 2'd2, 32'h208);
        dhit = 1;
        push(32'h200, 32'h208, 32'h0, 5'd0, 2'd2, 0);
        #1;
        chk("st_dmemWEN", dmemWEN, 1);
        chk("st_dmemstore", dmemstore, 32'h12345678);
        chk("st_stall", mem_stall, 0);
        step();
        dhit = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("st_after_dmemWEN", dmemWEN, 0);
        step();
        // ALU op then flushed op
        drive(1, 0, 0, 0, 32'd7, 0, 5'd5, 2'd0, 32'h300);
        push(32'd7, 32'h300, 32'h0, 5'd5, 2'd0, 0);
        #1;
        chk("alu_stall", mem_stall, 0);
        step();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wsel", wsel, 5);
        drive(1, 0, 0, 0, 32'd9, 0, 5'd9, 2'd0, 32'h304);
        flush = 1;
        step();
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_wsel", wsel, 0);
        flush = 0;
        // load+store together is a load only
        drive(1, 1, 1, 0, 32'h280, 32'h1, 5'd4, 2'd1, 32'h284);
        dhit = 1; dmemload = 32'hCAFE;
        push(32'h280, 32'h284, 32'hCAFE, 5'd4, 2'd1, 0);
        #1;
        chk("both_dmemREN", dmemREN, 1);
        chk("both_dmemWEN", dmemWEN, 0);
        step();
        // flush during WAIT is ignored
        drive(1, 1, 0, 0, 32'h2C0, 0, 5'd6, 2'd1, 32'h2C4);
        dhit = 0;
        push(32'h2C0, 32'h2C4, 32'h0BAD, 5'd6, 2'd1, 0);
        step();
        flush = 1; dhit = 1; dmemload = 32'h0BAD;
        #1;
        chk("wflush_dmemREN", dmemREN, 1);
        step();
        flush = 0; dhit = 0;
        // 20 stall cycles: 16-bit counter counts on, 4-bit counter saturates
        drive(1, 1, 0, 0, 32'h400, 0, 5'd7, 2'd1, 32'h404);
        push(32'h400, 32'h404, 32'h55, 5'd7, 2'd1, 0);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("sat_stall", mem_stall, 1);
            step();
        end
        dhit = 1; dmemload = 32'h55;
        step();
        dhit = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("cnt16", stall_cycles, 24);
        chk("cnt4_sat", {28'd0, n_cnt}, 32'd15);
        step();
        // halt wins over a load, then sticks
        drive(1, 1, 0, 1, 32'h500, 0, 5'd1, 2'd0, 32'h504);
        push(32'h500, 32'h504, 32'h0, 5'd1, 2'd0, 1);
        #1;
        chk("halt_dmemREN", dmemREN, 0);
        chk("halt_stall", mem_stall, 0);
        step();
        drive(1, 1, 0, 0, 32'h600, 0, 5'd2, 2'd0, 32'h604);
        #1;
        chk("halted_halt", halt, 1);
        chk("halted_dmemREN", dmemREN, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halted_wb_valid", wb_valid, 0);
            chk("halted_sticky", halt, 1);
            chk("halted_no_req", dmemREN, 0);
        end
        // reset during a pending load
        RST = 1;
        #1;
        RST = 0;
        step();
        chk("rw_dmemREN", dmemREN, 1);
        chk("rw_stall", mem_stall, 1);
        #2;
        RST = 1;
        #1;
        chk("rw_rst_dmemREN", dmemREN, 0);
        chk("rw_rst_wb_valid", wb_valid, 0);
        chk("rw_rst_cnt", stall_cycles, 0);
        chk("rw_rst_halt", halt, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 0;
        step();
        chk("rw_idle_dmemREN", dmemREN, 0);
        chk("rw_idle_stall", mem_stall, 0);
        chk("rw_idle_cnt", stall_cycles, 0);
        step();
        chk("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
